ring_router_gateway_multi: RTL

Ring NoC router with gateway functionality generalised to NUM_EXT external ports, each serving one remote subnet set by a parameter map. It routes at packet granularity using the destination ID in the first flit. Traffic for subnets that are neither local nor mapped is dropped and counted. It sits on the debug ring in place of the single-port gateway wherever a subnet bridges to several others.

---
 rtl/ring_router_gateway_multi.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ring_router_gateway_multi.sv
// Ring router with multi-port gateway: packet demux per ring input, packet-locked
// round-robin arbiters, and buffered ring outputs. Unroutable packets are dropped and counted.

package dii_package;
   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;
endpackage

module ring_router_gateway_multi_arb
   import dii_package::*;
#(
   parameter int N     = 2,
   parameter bit PRIO0 = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  dii_flit [N-1:0] req,
   output logic [N-1:0]    req_ready,
   output dii_flit         out,
   input  logic            out_ready
);
   localparam int BASE = PRIO0 ? 1 : 0;
   localparam int M    = N - BASE;

   logic       locked_r;
   logic [2:0] grant_r, ptr_r, sel_s, win_s, hi_win_s, any_win_s;
   logic       hi_found_s, any_found_s, act_s, rr_pick_s, xfer_s;

   // Winner selection: held grant when locked, else input 0 priority, else round-robin
   always_comb begin
      hi_found_s  = 1'b0;
      any_found_s = 1'b0;
      hi_win_s    = 3'd0;
      any_win_s   = 3'd0;
      for (int j = M - 1; j >= 0; j--) begin
         any_win_s   = req[BASE+j].valid ? 3'(j) : any_win_s;
         any_found_s = any_found_s | req[BASE+j].valid;
         hi_win_s    = (req[BASE+j].valid && j >= int'(ptr_r)) ? 3'(j) : hi_win_s;
         hi_found_s  = hi_found_s | (req[BASE+j].valid && j >= int'(ptr_r));
      end
      win_s = hi_found_s ? hi_win_s : any_win_s;
      if (locked_r) begin
         sel_s     = grant_r;
         act_s     = 1'b1;
         rr_pick_s = 1'b0;
      end else if (PRIO0 && req[0].valid) begin
         sel_s     = 3'd0;
         act_s     = 1'b1;
         rr_pick_s = 1'b0;
      end else begin
         sel_s     = 3'(BASE) + win_s;
         act_s     = any_found_s;
         rr_pick_s = 1'b1;
      end
   end

   // Output mux and per-source ready; only the selected source sees the sink ready
   always_comb begin
      out       = '0;
      req_ready = '0;
      for (int j = 0; j < N; j++) begin
         out          = (act_s && sel_s == 3'(j)) ? req[j] : out;
         req_ready[j] = act_s && (sel_s == 3'(j)) && out_ready;
      end
   end

   assign xfer_s = out.valid && out_ready;

   // Lock on a non-last flit, unlock after the last; the pointer moves past a round-robin winner
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         locked_r <= 1'b0;
         grant_r  <= 3'd0;
         ptr_r    <= 3'd0;
      end else if (xfer_s) begin
         locked_r <= !out.last;
         grant_r  <= sel_s;
         if (rr_pick_s) ptr_r <= (win_s == 3'(M - 1)) ? 3'd0 : win_s + 3'd1;
      end
   end
endmodule

module ring_router_gateway_multi_fifo
   import dii_package::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  dii_flit in,
   output logic    in_ready,
   output dii_flit out,
   input  logic    out_ready
);
   localparam int AW = $clog2(DEPTH);

   dii_flit       mem_r [DEPTH];
   logic [AW-1:0] wr_r, rd_r;
   logic [AW:0]   cnt_r;
   logic          push_s, pop_s;

   assign in_ready = (cnt_r != (AW + 1)'(DEPTH));
   assign out      = (cnt_r == '0) ? '0 : mem_r[rd_r];
   assign push_s   = in.valid && in_ready;
   assign pop_s    = out.valid && out_ready;

   // Storage array, written on push
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wr_r] <= in;
   end

   // Pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_r  <= '0;
         rd_r  <= '0;
         cnt_r <= '0;
      end else begin
         if (push_s) wr_r <= wr_r + 1'b1;
         if (pop_s)  rd_r <= rd_r + 1'b1;
         case ({push_s, pop_s})
            2'b10:   cnt_r <= cnt_r + 1'b1;
            2'b01:   cnt_r <= cnt_r - 1'b1;
            default: cnt_r <= cnt_r;
         endcase
      end
   end
endmodule

module ring_router_gateway_multi
   import dii_package::*;
#(
   parameter int BUFFER_SIZE  = 4,
   parameter int SUBNET_BITS  = 6,
   parameter int LOCAL_SUBNET = 0,
   parameter int NUM_EXT      = 2,
   parameter logic [NUM_EXT*SUBNET_BITS-1:0] EXT_SUBNET_MAP = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [15:0]           id,
   input  dii_flit               ring_in0,
   output logic                  ring_in0_ready,
   input  dii_flit               ring_in1,
   output logic                  ring_in1_ready,
   output dii_flit               ring_out0,
   input  logic                  ring_out0_ready,
   output dii_flit               ring_out1,
   input  logic                  ring_out1_ready,
   input  dii_flit               local_in,
   output logic                  local_in_ready,
   output dii_flit               local_out,
   input  logic                  local_out_ready,
   input  dii_flit [NUM_EXT-1:0] ext_in,
   output logic [NUM_EXT-1:0]    ext_in_ready,
   output dii_flit [NUM_EXT-1:0] ext_out,
   input  logic [NUM_EXT-1:0]    ext_out_ready,
   output logic [15:0]           drop_count
);
   localparam logic [2:0] T_LOCAL = 3'd0;
   localparam logic [2:0] T_FWD   = 3'd1;
   localparam logic [2:0] T_DROP  = 3'd2;
   localparam logic [2:0] T_EXT   = 3'd3;

   typedef enum logic {IDLE = 1'b0, ROUTE = 1'b1} dmx_state_e;

   dii_flit [1:0]              rin_s, loc_req_s, fwd_s;
   logic [1:0]                 in_rdy_s, loc_rdy_s, fwd_rdy_s, drop_s;
   dii_flit [NUM_EXT-1:0][1:0] ext_req_s;
   logic [NUM_EXT-1:0][1:0]    ext_rdy_s;
   dii_flit [NUM_EXT+1:0]      r0_req_s;
   logic [NUM_EXT+1:0]         r0_rdy_s;
   dii_flit                    r0_flit_s;
   logic                       r0_flit_ready_s;
   logic [16:0]                drop_sum_s;

   // Lowest matching ext slot wins; own ID beats local subnet beats ext map
   function automatic logic [2:0] route(input logic [15:0] dest, input logic [15:0] self_id);
      logic [SUBNET_BITS-1:0] sub;
      logic [2:0]             ext;
      sub = dest[15 -: SUBNET_BITS];
      ext = T_DROP;
      for (int k = NUM_EXT - 1; k >= 0; k--)
         ext = (sub == EXT_SUBNET_MAP[k*SUBNET_BITS +: SUBNET_BITS]) ? T_EXT + 3'(k) : ext;
      if (dest == self_id) route = T_LOCAL;
      else if (sub == SUBNET_BITS'(LOCAL_SUBNET)) route = T_FWD;
      else route = ext;
   endfunction

   function automatic dii_flit gate(input dii_flit f, input logic en);
      gate       = f;
      gate.valid = f.valid & en;
   endfunction

   assign rin_s[0]       = ring_in0;
   assign rin_s[1]       = ring_in1;
   assign ring_in0_ready = in_rdy_s[0];
   assign ring_in1_ready = in_rdy_s[1];

   for (genvar i = 0; i < 2; i++) begin : g_dmx
      dmx_state_e state_r;
      logic [2:0] target_r, tgt_s;
      logic       rdy_s;

      assign tgt_s = (state_r == IDLE) ? route(rin_s[i].data, id) : target_r;

      // Ready follows the selected target; dropped flits are always accepted
      always_comb begin
         rdy_s = 1'b0;
         case (tgt_s)
            T_LOCAL: rdy_s = loc_rdy_s[i];
            T_FWD:   rdy_s = fwd_rdy_s[i];
            T_DROP:  rdy_s = 1'b1;
            default: begin
               for (int k = 0; k < NUM_EXT; k++)
                  rdy_s = (tgt_s == T_EXT + 3'(k)) ? ext_rdy_s[k][i] : rdy_s;
            end
         endcase
      end

      assign in_rdy_s[i]  = rdy_s;
      assign loc_req_s[i] = gate(rin_s[i], tgt_s == T_LOCAL);
      assign fwd_s[i]     = gate(rin_s[i], tgt_s == T_FWD);
      assign drop_s[i]    = (state_r == IDLE) && rin_s[i].valid && (tgt_s == T_DROP);

      for (genvar k = 0; k < NUM_EXT; k++) begin : g_ext_req
         assign ext_req_s[k][i] = gate(rin_s[i], tgt_s == T_EXT + 3'(k));
      end

      // Demux FSM: decision latched on the first flit, held until the last flit transfers
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_r  <= IDLE;
            target_r <= T_LOCAL;
         end else begin
            case (state_r)
               IDLE: if (rin_s[i].valid && rdy_s && !rin_s[i].last) begin
                  state_r  <= ROUTE;
                  target_r <= tgt_s;
               end
               ROUTE: if (rin_s[i].valid && rdy_s && rin_s[i].last) state_r <= IDLE;
               default: state_r <= IDLE;
            endcase
         end
      end
   end

   assign drop_sum_s = {1'b0, drop_count} + 17'(drop_s[0]) + 17'(drop_s[1]);

   // Saturating drop counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) drop_count <= 16'h0000;
      else drop_count <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
   end

   assign r0_req_s     = {ext_in, local_in, fwd_s[0]};
   assign fwd_rdy_s[0] = r0_rdy_s[0];
   assign local_in_ready = r0_rdy_s[1];
   assign ext_in_ready = r0_rdy_s[NUM_EXT+1:2];

   ring_router_gateway_multi_arb #(.N(NUM_EXT + 2), .PRIO0(1'b1)) u_arb_ring0 (
      .clk(clk), .rst(rst), .req(r0_req_s), .req_ready(r0_rdy_s),
      .out(r0_flit_s), .out_ready(r0_flit_ready_s)
   );

   ring_router_gateway_multi_fifo #(.DEPTH(BUFFER_SIZE)) u_fifo0 (
      .clk(clk), .rst(rst), .in(r0_flit_s), .in_ready(r0_flit_ready_s),
      .out(ring_out0), .out_ready(ring_out0_ready)
   );

   ring_router_gateway_multi_fifo #(.DEPTH(BUFFER_SIZE)) u_fifo1 (
      .clk(clk), .rst(rst), .in(fwd_s[1]), .in_ready(fwd_rdy_s[1]),
      .out(ring_out1), .out_ready(ring_out1_ready)
   );

   ring_router_gateway_multi_arb #(.N(2), .PRIO0(1'b0)) u_arb_local (
      .clk(clk), .rst(rst), .req(loc_req_s), .req_ready(loc_rdy_s),
      .out(local_out), .out_ready(local_out_ready)
   );

   for (genvar k = 0; k < NUM_EXT; k++) begin : g_ext_arb
      ring_router_gateway_multi_arb #(.N(2), .PRIO0(1'b0)) u_arb_ext (
         .clk(clk), .rst(rst), .req(ext_req_s[k]), .req_ready(ext_rdy_s[k]),
         .out(ext_out[k]), .out_ready(ext_out_ready[k])
      );
   end
endmodule
